mac_sequencer: RTL and testbench

Controller that sequences the NPU MAC datapath for one TAPS-length dot product per start request, with the coefficient bank chosen by c_select. Each job runs as two identical passes, primary then check. The two results are compared to detect transient MAC/multiplier faults, and on mismatch the job is retried up to MAX_RETRY times. It sits between the top-level user inputs (start button, bank select) and the MAC datapath plus LED display.

---
 rtl/mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_mac_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Sequences one TAPS-length dot product per start edge as a primary pass plus a
// check pass; mismatching passes trigger a full rerun, up to MAX_RETRY times.
module mac_sequencer #(
  parameter int TAPS      = 8,
  parameter int ADDR_W    = 3,
  parameter int ACC_W     = 16,
  parameter int MAC_LAT   = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          c_select,
  input  logic [ACC_W-1:0]    acc_in,
  output logic [2+ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0]   data_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                busy,
  output logic [ACC_W-1:0]    res,
  output logic                res_valid,
  output logic                err,
  output logic [7:0]          led,
  output logic [2:0]          dbg_state
);

  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_start_q;
  logic [1:0]          r_bank;
  logic [ADDR_W-1:0]   r_tap;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pass;
  logic [RT_W-1:0]     r_retry;
  logic [ACC_W-1:0]    r_shadow;
  logic [ACC_W-1:0]    r_res;
  logic                r_err;
  logic [7:0]          r_led;
  logic                w_start_edge;
  logic                w_last_tap;
  logic                w_drain_end;
  logic                w_match;
  logic                w_can_retry;

  assign w_start_edge = start & ~r_start_q;
  assign w_last_tap   = (r_tap == ADDR_W'(TAPS - 1));
  assign w_drain_end  = (r_cnt == CNT_W'(MAC_LAT - 1));
  assign w_match      = (acc_in == r_shadow);
  assign w_can_retry  = (r_retry < RT_W'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_edge) w_next = S_CLR;
      S_CLR:     w_next = S_RUN;
      S_RUN:     if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN:   if (w_drain_end) w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (!r_pass)          w_next = S_CLR;
        else if (w_match)     w_next = S_DONE;
        else if (w_can_retry) w_next = S_CLR;
        else                  w_next = S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_bank    <= '0;
      r_tap     <= '0;
      r_cnt     <= '0;
      r_pass    <= 1'b0;
      r_retry   <= '0;
      r_shadow  <= '0;
      r_res     <= '0;
      r_err     <= 1'b0;
      r_led     <= '0;
    end else begin
      r_start_q <= start;
      case (r_state)
        S_IDLE: if (w_start_edge) begin
          // Bank is frozen here so mid-job select changes cannot split a job.
          r_bank  <= c_select;
          r_err   <= 1'b0;
          r_pass  <= 1'b0;
          r_retry <= '0;
        end
        S_CLR: begin
          r_tap <= '0;
          r_cnt <= '0;
        end
        S_RUN:   r_tap <= w_last_tap ? '0 : r_tap + ADDR_W'(1);
        S_DRAIN: r_cnt <= r_cnt + CNT_W'(1);
        S_CAPTURE: begin
          if (!r_pass) begin
            r_shadow <= acc_in;
            r_pass   <= 1'b1;
          end else if (w_match) begin
            r_res <= acc_in;
          end else if (w_can_retry) begin
            r_retry <= r_retry + RT_W'(1);
            r_pass  <= 1'b0;
          end else begin
            r_res <= acc_in;
            r_err <= 1'b1;
          end
        end
        S_DONE:  r_led <= r_err ? 8'hFF : r_res[7:0];
        default: ;
      endcase
    end
  end

  assign coef_addr = {r_bank, r_tap};
  assign data_addr = r_tap;
  assign mac_clr   = (r_state == S_CLR);
  assign mac_en    = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign err       = r_err;
  assign led       = r_led;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: behavioural MAC model with optional
// check-pass fault injection, latency/result/LED checks per job.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  c_select;
  logic [15:0] acc_in;
  logic [4:0]  coef_addr;
  logic [2:0]  data_addr;
  logic        mac_clr;
  logic        mac_en;
  logic        busy;
  logic [15:0] res;
  logic        res_valid;
  logic        err;
  logic [7:0]  led;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // MAC model state
  logic [15:0] m_acc   = '0;
  logic [15:0] m_acc_d = '0;
  int          clr_cnt = 0;
  int          job_base = 0;
  int          inj_mode = 0;
  logic [1:0]  exp_bank = '0;
  int          bank_err = 0;
  logic        inject;

  mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .c_select(c_select), .acc_in(acc_in),
    .coef_addr(coef_addr), .data_addr(data_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .busy(busy), .res(res), .res_valid(res_valid), .err(err), .led(led),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mac_clr) begin
      m_acc   <= '0;
      clr_cnt <= clr_cnt + 1;
    end else if (mac_en) begin
      m_acc <= m_acc + ({14'd0, coef_addr[4:3]} + 16'd1) * {13'd0, coef_addr[2:0]};
    end
    m_acc_d <= m_acc;
  end

  always_comb begin
    inject = 1'b0;
    if (inj_mode == 1 && (clr_cnt - job_base) == 2) inject = 1'b1;
    if (inj_mode == 2 && (clr_cnt - job_base) > 0 && ((clr_cnt - job_base) % 2) == 0) inject = 1'b1;
  end
  assign acc_in = m_acc_d + {15'd0, inject};

  always @(negedge clk) begin
    if (mac_en && coef_addr[4:3] != exp_bank) bank_err <= bank_err + 1;
    if (mac_en && data_addr != coef_addr[2:0]) bank_err <= bank_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [1:0] sel, input logic [1:0] sel_after,
                         input int mode, input int exp_lat, input logic [15:0] exp_res,
                         input logic exp_err, input logic [7:0] exp_led);
    int lat, busy_n, nv, bank_err0;
    logic [15:0] got_res;
    logic got_err;
    logic [7:0] got_led;
    lat = -1; busy_n = 0; nv = 0; got_res = '0; got_err = 1'b0; got_led = '0;
    @(negedge clk);
    inj_mode = mode;
    job_base = clr_cnt;
    exp_bank = sel;
    bank_err0 = bank_err;
    c_select = sel;
    start = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        c_select = sel_after;
      end
      if (busy) busy_n++;
      if (res_valid) begin
        nv++;
        if (lat < 0) begin
          lat = n;
          got_res = res;
          got_err = err;
        end
      end
      if (lat > 0 && n == lat + 1) got_led = led;
      if (lat > 0 && n >= lat + 2) break;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, {16'd0, got_res}, {16'd0, exp_res});
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, "_led"}, {24'd0, got_led}, {24'd0, exp_led});
    chk({tag, "_busy"}, busy_n, exp_lat);
    chk({tag, "_nvalid"}, nv, 1);
    chk({tag, "_bank"}, bank_err - bank_err0, 0);
    inj_mode = 0;
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    start = 1'b0;
    c_select = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, dbg_state}, 0);
    chk("rst_outs", {mac_clr, mac_en, busy, res_valid, err, coef_addr, data_addr}, 0);
    chk("rst_res_led", {res, led}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_job("basic", 2'd0, 2'd0, 0, 25, 16'd28, 1'b0, 8'h1C);
    run_job("selchg", 2'd3, 2'd1, 0, 25, 16'd112, 1'b0, 8'h70);
    run_job("retry", 2'd2, 2'd2, 1, 49, 16'd84, 1'b0, 8'h54);
    run_job("fail", 2'd1, 2'd1, 2, 49, 16'd57, 1'b1, 8'hFF);
    repeat (5) @(negedge clk);
    chk("err_hold", {31'd0, err}, 1);
    run_job("clean", 2'd1, 2'd1, 0, 25, 16'd56, 1'b0, 8'h38);

    // Held start with extra edges while busy: exactly one job.
    nv = 0;
    c_select = 2'd0;
    exp_bank = 2'd0;
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 10 || n == 20) start = 1'b0;
      if (n == 11 || n == 22) start = 1'b1;
      if (res_valid) nv++;
    end
    chk("held_nvalid", nv, 1);
    chk("held_idle", {29'd0, dbg_state}, 0);
    start = 1'b0;
    nv = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (res_valid || busy) nv++;
    end
    chk("held_nojob", nv, 0);
    run_job("after_held", 2'd0, 2'd0, 0, 25, 16'd28, 1'b0, 8'h1C);

    // Reset mid-job aborts immediately.
    @(negedge clk);
    c_select = 2'd2;
    start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    chk("mid_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_state", {29'd0, dbg_state}, 0);
    chk("rst_mid_outs", {mac_clr, mac_en, busy, res_valid, err, coef_addr, data_addr}, 0);
    chk("rst_mid_led", {24'd0, led}, 0);
    chk("rst_mid_res", {16'd0, res}, 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (res_valid || busy) nv++;
    end
    chk("rst_noresult", nv, 0);
    run_job("after_rst", 2'd2, 2'd2, 0, 25, 16'd84, 1'b0, 8'h54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
